// File: rtl/demux_lane_sequencer_if.sv
// Word-stream and demux-side signal bundle for the lane sequencer.
// The slave modport is the sequencer; master is whatever sits around it
// (upstream feeder plus the demux lanes reporting space).
interface demux_lane_sequencer_if #(
  parameter int size = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [size-1:0] in_data;
  logic [3:0]      lane_ready;
  logic [1:0]      sel;
  logic [size-1:0] d_out;
  logic [3:0]      wr_en;

  modport master (
    output in_valid, in_data, lane_ready,
    input  in_ready, sel, d_out, wr_en
  );

  modport slave (
    input  in_valid, in_data, lane_ready,
    output in_ready, sel, d_out, wr_en
  );
endinterface

// File: rtl/demux_lane_sequencer.sv
// Feeds a 1:4 demux: BURST_LEN accepted words go to each lane in order
// 0,1,2,3, then a one-cycle frame_done marks the end of the frame.
module demux_lane_sequencer #(
  parameter int size      = 8,
  parameter int BURST_LEN = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   clear,
  demux_lane_sequencer_if.slave  bus,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]       lane_q, lane_d;
  logic [1:0]       sel_q;
  logic [size-1:0]  d_out_q;
  logic [3:0]       wr_en_q;
  logic             accept;

  // clear forces in_ready low, so an aborting cycle can never accept a word.
  assign bus.in_ready = (state_q == STREAM) && bus.lane_ready[lane_q] && !clear;
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.sel    = sel_q;
  assign bus.d_out  = d_out_q;
  assign bus.wr_en  = wr_en_q;
  assign busy       = (state_q == STREAM);
  assign frame_done = (state_q == DONE);

  // State and counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      lane_q     <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      lane_q     <= lane_d;
    end
  end

  // Next-state and counter update; clear overrides everything.
  // NOTE: every target gets a default first so no path leaves a latch.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    lane_d     = lane_q;
    if (clear) begin
      state_d    = IDLE;
      word_cnt_d = '0;
      lane_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d    = STREAM;
            word_cnt_d = '0;
            lane_d     = '0;
          end
        end
        STREAM: begin
          if (accept) begin
            if (word_cnt_q == LAST_WORD) begin
              word_cnt_d = '0;
              // Wrap from lane 3 back to 0 is harmless: the frame ends here.
              lane_d     = lane_q + 2'd1;
              if (lane_q == 2'd3) state_d = DONE;
            end else begin
              word_cnt_d = word_cnt_q + CNT_W'(1);
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Registered demux drive: data and strobe only in the cycle after an
  // accept, zeros otherwise; sel keeps pointing at the last lane written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      d_out_q <= '0;
      wr_en_q <= '0;
    end else if (accept) begin
      sel_q   <= lane_q;
      d_out_q <= bus.in_data;
      wr_en_q <= 4'b0001 << lane_q;
    end else begin
      d_out_q <= '0;
      wr_en_q <= '0;
    end
  end

endmodule

// File: tb/tb_demux_lane_sequencer.sv
// Self-checking bench: a BURST_LEN=9 and a BURST_LEN=1 instance share the
// same stimulus, and each is compared every cycle against a word-count
// model of the frame (lane = words_accepted / BURST_LEN).
module tb_demux_lane_sequencer;

  logic clk = 1'b0;
  logic rst_n, start, clear;
  logic busy9, fd9, busy1, fd1;

  always #5 clk = ~clk;

  demux_lane_sequencer_if #(.size(8)) bus9 ();
  demux_lane_sequencer_if #(.size(8)) bus1 ();

  demux_lane_sequencer #(.size(8), .BURST_LEN(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .bus(bus9.slave), .busy(busy9), .frame_done(fd9)
  );

  demux_lane_sequencer #(.size(8), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .bus(bus1.slave), .busy(busy1), .frame_done(fd1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model, one slot per instance.
  int         bl[2] = '{9, 1};
  bit         m_active[2];
  bit         m_done[2];
  int         m_n[2];
  logic [1:0] m_sel[2];
  logic [7:0] m_d[2];
  logic [3:0] m_wr[2];

  int         writes9;
  int         fd9_count;
  logic [3:0] last_wr1;
  logic       last_fd1;

  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 1'b0;
      m_done[k]   = 1'b0;
      m_n[k]      = 0;
      m_sel[k]    = '0;
      m_d[k]      = '0;
      m_wr[k]     = '0;
    end
  endtask

  // One clock of stimulus; called at a negedge, returns at the next negedge.
  task automatic step(input bit st, input bit clr, input bit v,
                      input logic [7:0] d, input logic [3:0] lr);
    int   ln;
    bit   exp_rdy, acc, n_active, n_done;
    int   n_n;
    logic got_rdy, got_busy, got_fd;
    logic [1:0] got_sel;
    logic [7:0] got_d;
    logic [3:0] got_wr;
    start = st;
    clear = clr;
    bus9.in_valid = v;   bus1.in_valid = v;
    bus9.in_data  = d;   bus1.in_data  = d;
    bus9.lane_ready = lr; bus1.lane_ready = lr;
    #1;
    for (int k = 0; k < 2; k++) begin
      ln      = (m_n[k] / bl[k]) % 4;
      exp_rdy = m_active[k] && lr[ln] && !clr;
      got_rdy = (k == 0) ? bus9.in_ready : bus1.in_ready;
      checks++;
      if (got_rdy !== exp_rdy) begin
        errors++;
        $display("FAIL in_ready dut%0d t=%0t got %b expected %b", k, $time, got_rdy, exp_rdy);
      end
      acc = v && exp_rdy;
      if (acc) begin
        m_wr[k]  = 4'b0001 << ln;
        m_d[k]   = d;
        m_sel[k] = ln[1:0];
      end else begin
        m_wr[k] = '0;
        m_d[k]  = '0;
      end
      n_active = m_active[k];
      n_done   = 1'b0;
      n_n      = m_n[k];
      if (clr) begin
        n_active = 1'b0;
        n_n      = 0;
      end else if (m_done[k]) begin
        n_active = 1'b0;
      end else if (m_active[k]) begin
        if (acc) begin
          n_n = m_n[k] + 1;
          if (n_n == 4 * bl[k]) begin
            n_active = 1'b0;
            n_done   = 1'b1;
            n_n      = 0;
          end
        end
      end else if (st) begin
        n_active = 1'b1;
        n_n      = 0;
      end
      m_active[k] = n_active;
      m_done[k]   = n_done;
      m_n[k]      = n_n;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      got_wr   = (k == 0) ? bus9.wr_en : bus1.wr_en;
      got_d    = (k == 0) ? bus9.d_out : bus1.d_out;
      got_sel  = (k == 0) ? bus9.sel   : bus1.sel;
      got_busy = (k == 0) ? busy9 : busy1;
      got_fd   = (k == 0) ? fd9   : fd1;
      checks++;
      if (got_wr !== m_wr[k] || got_d !== m_d[k] || got_sel !== m_sel[k]) begin
        errors++;
        $display("FAIL demux_out dut%0d t=%0t got wr=%b d=%h sel=%0d expected wr=%b d=%h sel=%0d",
                 k, $time, got_wr, got_d, got_sel, m_wr[k], m_d[k], m_sel[k]);
      end
      checks++;
      if (got_busy !== m_active[k] || got_fd !== m_done[k]) begin
        errors++;
        $display("FAIL status dut%0d t=%0t got busy=%b done=%b expected busy=%b done=%b",
                 k, $time, got_busy, got_fd, m_active[k], m_done[k]);
      end
    end
    if (bus9.wr_en != 4'b0) writes9++;
    if (fd9) fd9_count++;
    last_wr1 = bus1.wr_en;
    last_fd1 = fd1;
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 8'h00, 4'hF);
  endtask

  // Idle until both instances are back in IDLE, with a cycle budget.
  task automatic quiesce();
    int i;
    for (i = 0; i < 20; i++) begin
      if (!m_active[0] && !m_done[0] && !m_active[1] && !m_done[1]) break;
      idle_step();
    end
    checks++;
    if (i == 20) begin
      errors++;
      $display("FAIL quiesce_timeout got busy9=%b expected idle", busy9);
    end
    idle_step();
  endtask

  // Stream random words (optionally every other cycle) until the 9-word
  // instance reaches target accepted words or its frame ends.
  task automatic feed(input int target, input bit bubbles);
    int i;
    for (i = 0; i < 400; i++) begin
      if (!m_active[0] || m_n[0] >= target) break;
      step(1'b0, 1'b0, bubbles ? (i % 2 == 0) : 1'b1, 8'($urandom), 4'hF);
    end
    checks++;
    if (i == 400) begin
      errors++;
      $display("FAIL feed_timeout got words=%0d expected %0d", m_n[0], target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; clear = 1'b0;
    bus9.in_valid = 1'b0; bus9.in_data = '0; bus9.lane_ready = 4'hF;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.lane_ready = 4'hF;
    reset_model();
    #1;
    checks++;
    if ({bus9.wr_en, bus9.d_out, bus9.sel, busy9, fd9, bus9.in_ready} !== 17'b0) begin
      errors++;
      $display("FAIL reset_outputs got wr=%b d=%h sel=%0d busy=%b done=%b rdy=%b expected all 0",
               bus9.wr_en, bus9.d_out, bus9.sel, busy9, fd9, bus9.in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_step();
    idle_step();
  endtask

  task automatic test_full_frame();
    int w0, f0;
    w0 = writes9; f0 = fd9_count;
    step(1'b1, 1'b0, 1'b0, 8'h00, 4'hF);
    for (int i = 1; i <= 36; i++) step(1'b0, 1'b0, 1'b1, 8'(i), 4'hF);
    checks++;
    if (fd9 !== 1'b1 || bus9.wr_en !== 4'b1000 || bus9.d_out !== 8'd36) begin
      errors++;
      $display("FAIL final_word got done=%b wr=%b d=%0d expected done=1 wr=1000 d=36",
               fd9, bus9.wr_en, bus9.d_out);
    end
    quiesce();
    checks++;
    if (writes9 - w0 != 36 || fd9_count - f0 != 1 || busy9 !== 1'b0) begin
      errors++;
      $display("FAIL full_frame got writes=%0d done_pulses=%0d busy=%b expected 36 1 0",
               writes9 - w0, fd9_count - f0, busy9);
    end
  endtask

  task automatic test_backpressure();
    int w0, stall, i;
    w0 = writes9; stall = 0;
    step(1'b1, 1'b0, 1'b0, 8'h00, 4'hF);
    for (i = 0; i < 200; i++) begin
      if (!m_active[0]) break;
      if (m_n[0] == 9 && stall < 5) begin
        stall++;
        step(1'b0, 1'b0, 1'b1, 8'($urandom), 4'b1101);
        checks++;
        if (bus9.wr_en !== 4'b0 || bus9.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall got wr=%b rdy=%b expected wr=0000 rdy=0", bus9.wr_en, bus9.in_ready);
        end
      end else begin
        step(1'b0, 1'b0, 1'b1, 8'($urandom), 4'hF);
      end
    end
    quiesce();
    checks++;
    if (writes9 - w0 != 36 || stall != 5) begin
      errors++;
      $display("FAIL backpressure got writes=%0d stalls=%0d expected 36 5", writes9 - w0, stall);
    end
  endtask

  task automatic test_bubbles();
    int w0;
    w0 = writes9;
    step(1'b1, 1'b0, 1'b0, 8'h00, 4'hF);
    feed(36, 1'b1);
    quiesce();
    checks++;
    if (writes9 - w0 != 36) begin
      errors++;
      $display("FAIL bubbles got writes=%0d expected 36", writes9 - w0);
    end
  endtask

  task automatic test_clear();
    int f0, w0;
    f0 = fd9_count;
    step(1'b1, 1'b0, 1'b0, 8'h00, 4'hF);
    feed(19, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h5A, 4'hF);
    checks++;
    if (bus9.wr_en !== 4'b0 || busy9 !== 1'b0) begin
      errors++;
      $display("FAIL clear_abort got wr=%b busy=%b expected wr=0000 busy=0", bus9.wr_en, busy9);
    end
    repeat (3) idle_step();
    checks++;
    if (fd9_count != f0) begin
      errors++;
      $display("FAIL clear_no_done got pulses=%0d expected %0d", fd9_count, f0);
    end
    w0 = writes9;
    step(1'b1, 1'b0, 1'b0, 8'h00, 4'hF);
    feed(36, 1'b0);
    quiesce();
    checks++;
    if (writes9 - w0 != 36 || fd9_count - f0 != 1) begin
      errors++;
      $display("FAIL clear_restart got writes=%0d pulses=%0d expected 36 1", writes9 - w0, fd9_count - f0);
    end
  endtask

  task automatic test_start_mid();
    int w0;
    w0 = writes9;
    step(1'b1, 1'b0, 1'b0, 8'h00, 4'hF);
    feed(4, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h77, 4'hF);
    feed(36, 1'b0);
    quiesce();
    checks++;
    if (writes9 - w0 != 36) begin
      errors++;
      $display("FAIL start_mid got writes=%0d expected 36", writes9 - w0);
    end
  endtask

  task automatic test_reset_mid();
    int f0;
    f0 = fd9_count;
    step(1'b1, 1'b0, 1'b0, 8'h00, 4'hF);
    feed(14, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus9.wr_en, bus9.d_out, bus9.sel, busy9} !== 15'b0) begin
      errors++;
      $display("FAIL reset_mid got wr=%b d=%h sel=%0d busy=%b expected all 0",
               bus9.wr_en, bus9.d_out, bus9.sel, busy9);
    end
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step(1'b0, 1'b0, 1'b1, 8'($urandom), 4'hF);
    checks++;
    if (fd9_count != f0) begin
      errors++;
      $display("FAIL reset_no_done got pulses=%0d expected %0d", fd9_count, f0);
    end
  endtask

  task automatic test_burst1();
    step(1'b1, 1'b0, 1'b0, 8'h00, 4'hF);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'hA1 + 8'(i), 4'hF);
      checks++;
      if (last_wr1 !== (4'b0001 << i) || last_fd1 !== (i == 3) || bus1.d_out !== 8'hA1 + 8'(i)) begin
        errors++;
        $display("FAIL burst1 word%0d got wr=%b done=%b d=%h expected wr=%b done=%b d=%h",
                 i, last_wr1, last_fd1, bus1.d_out, 4'b0001 << i, (i == 3), 8'hA1 + 8'(i));
      end
    end
    feed(36, 1'b0);
    quiesce();
  endtask

  task automatic test_random();
    int i;
    step(1'b1, 1'b0, 1'b0, 8'h00, 4'hF);
    for (i = 0; i < 600; i++) begin
      if (!m_active[0]) break;
      step(1'b0, 1'b0, 1'($urandom), 8'($urandom), 4'($urandom));
    end
    checks++;
    if (i == 600) begin
      errors++;
      $display("FAIL random_timeout got words=%0d expected 36", m_n[0]);
    end
    quiesce();
  endtask

  initial begin
    writes9 = 0; fd9_count = 0; last_wr1 = '0; last_fd1 = 1'b0;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_bubbles();
    test_clear();
    test_start_mid();
    test_reset_mid();
    test_burst1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got time=%0t expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/demux_lane_sequencer.md
Name: demux_lane_sequencer

Overview:
Upstream feeder for the 1:4 demux in the CNN datapath. Accepts a valid/ready word stream, such as kernel weights or feature-map pixels. Generates the demux select, a registered data word, and a one-hot write strobe so each of 4 downstream lanes (PE rows or line buffers) receives BURST_LEN consecutive words in lane order 0,1,2,3. Signals end of frame after all 4 lanes are loaded.

Parameters:
size, 8, data word width; matches the demux data width.
BURST_LEN, 9, words per lane per frame (3x3 kernel); legal range 1..256.
CNT_W, $clog2(BURST_LEN) min 1, local width of the word counter; derived, not overridable.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle request to begin a frame; honoured only in IDLE.
clear  in  1  synchronous abort; returns to IDLE and drops the frame.
in_valid  in  1  upstream word valid.
in_ready  out  1  sequencer can accept a word this cycle.
in_data  in  size  upstream word.
lane_ready  in  4  per-lane space available, bit i = lane i.
sel  out  2  demux select, drives demux sel.
d_out  out  size  registered word, drives demux d_in.
wr_en  out  4  one-hot write strobe for the selected lane.
busy  out  1  high in STREAM.
frame_done  out  1  one-cycle pulse after the last word of lane 3 is issued.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, word_cnt=0, lane=0, sel=0, d_out=0, wr_en=0, in_ready=0, busy=0, frame_done=0.
- FSM states: IDLE, STREAM, DONE.
  - IDLE -> STREAM when start=1; word_cnt and lane are cleared to 0.
  - STREAM -> DONE on the accepted word where lane=3 and word_cnt=BURST_LEN-1.
  - DONE -> IDLE unconditionally after 1 cycle; frame_done=1 only in that cycle.
- in_ready is combinational: (state==STREAM) && lane_ready[lane] && !clear.
- A word is accepted when in_valid && in_ready.
- Latency 1 cycle. The cycle after an accept: d_out=in_data, sel=lane at accept time, wr_en=(4'b0001<<lane), all registered.
- In any cycle without an accept: wr_en=0 and d_out=0, so the demux drives zeros. sel holds its last value.
- Counters on accept:
  - if word_cnt==BURST_LEN-1: word_cnt<=0 and lane<=lane+1 (2-bit; the wrap from 3 is masked by the DONE transition).
  - otherwise word_cnt<=word_cnt+1.
- Backpressure: if lane_ready[lane]=0, in_ready=0 and the stall lasts indefinitely. No lane is skipped and counters hold.
- start while in STREAM or DONE is ignored and does not restart the frame.
- clear=1 in any state: next state IDLE, counters to 0, wr_en=0 next cycle, no frame_done.
  - clear has priority over start and over an accept in the same cycle; that word is not accepted because in_ready is forced low.
- BURST_LEN=1: each lane gets one word. A frame is 4 accepts, and DONE follows the 4th accept.
- busy=1 exactly while state==STREAM.
- wr_en of the final word and frame_done assert in the same cycle (the DONE cycle).
- Reset asserted mid-frame: all outputs clear immediately (async). No partial-frame completion is signalled after release.

Test Plan:
1. BURST_LEN=9, start, in_valid always 1, lane_ready=4'hF, data 1..36.
   - in_ready high for 36 consecutive cycles.
   - wr_en=0001 for words 1-9, 0010 for 10-18, 0100 for 19-27, 1000 for 28-36; sel tracks 0..3; d_out equals the accepted word delayed 1 cycle.
   - frame_done pulses once, in the same cycle as the wr_en of word 36; then IDLE with busy=0.
2. Backpressure: lane_ready[1]=0 from word 10 for 5 cycles.
   - in_ready=0 and wr_en=0 for those 5 cycles.
   - Resumes with word 10 to lane 1 and no word lost; 36 total writes.
3. Bubbles: in_valid toggled 1,0,1,0.
   - wr_en pulses only the cycle after each valid beat; d_out=0 in the gaps; lane boundaries still at word counts 9/18/27.
4. clear asserted at word 20 (lane 2) together with in_valid=1.
   - Word 20 not accepted; next cycle wr_en=0 and state IDLE; no frame_done.
   - A new start begins again at lane 0, word_cnt 0.
5. start pulsed mid-frame at word 5: ignored, and lane sequencing is unchanged.
   - Separately: rst_n low at word 15 immediately zeros sel, d_out, wr_en and busy.
6. BURST_LEN=1 build, 4 words 0xA1..0xA4: wr_en=0001,0010,0100,1000 in consecutive cycles, and frame_done in the cycle of wr_en=1000.
